// File: rtl/grf_wb_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : grf_wb_arbiter                                               |
// | Purpose : Shares the single GRF write port between the W stage and a   |
// |           queued long-latency unit; tracks outstanding LU writes per   |
// |           register and forces a W bubble when queued results starve.   |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module grf_wb_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  w_a3,
  input  logic [31:0] w_wd,
  input  logic [31:0] w_pc,
  input  logic        lu_issue,
  input  logic [4:0]  lu_issue_a3,
  output logic        lu_issue_ok,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_a3,
  input  logic [31:0] lu_wd,
  input  logic [31:0] lu_pc,
  input  logic [4:0]  rd_a1,
  input  logic [4:0]  rd_a2,
  output logic        busy1,
  output logic        busy2,
  output logic        pipe_stall,
  output logic [4:0]  grf_a3,
  output logic [31:0] grf_wd,
  output logic [31:0] grf_pc
);

  localparam int                 c_AW   = $clog2(DEPTH);
  localparam int                 c_WW   = $clog2(MAX_WAIT + 1);
  localparam logic [c_AW:0]      c_PONE = (c_AW + 1)'(1);
  localparam logic [CNT_W-1:0]   c_CONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]   c_MAXC = '1;
  localparam logic [c_WW-1:0]    c_WONE = c_WW'(1);
  localparam logic [c_WW-1:0]    c_MAXW = c_WW'(MAX_WAIT);

  // LU result FIFO storage; pointers carry one extra wrap bit for full/empty
  logic [4:0]      r_fa3 [DEPTH];
  logic [31:0]     r_fwd [DEPTH];
  logic [31:0]     r_fpc [DEPTH];
  logic [c_AW:0]   r_wr;
  logic [c_AW:0]   r_rd;

  logic [CNT_W-1:0] r_cnt [32];
  logic [c_WW-1:0]  r_wait;

  logic        w_empty;
  logic        w_full;
  logic        w_wstage;
  logic        w_retire;
  logic        w_push;
  logic [4:0]  w_head_a3;
  logic [31:0] w_head_wd;
  logic [31:0] w_head_pc;
  logic [4:0]  w_ret_a3;
  logic        w_issue_eff;
  logic [31:0] w_inc;
  logic [31:0] w_dec;
  logic [CNT_W-1:0] w_b1_cnt;
  logic [CNT_W-1:0] w_b2_cnt;

  assign w_empty   = (r_wr == r_rd);
  assign w_full    = (r_wr[c_AW] != r_rd[c_AW]) &&
                     (r_wr[c_AW-1:0] == r_rd[c_AW-1:0]);
  assign w_wstage  = (w_a3 != 5'd0);
  assign w_head_a3 = r_fa3[r_rd[c_AW-1:0]];
  assign w_head_wd = r_fwd[r_rd[c_AW-1:0]];
  assign w_head_pc = r_fpc[r_rd[c_AW-1:0]];

  // The head retires only into a slot the W stage leaves free; a freshly
  // pushed entry is not yet visible at the head, so there is no bypass.
  assign w_retire  = !reset && !w_wstage && !w_empty;
  assign w_ret_a3  = w_retire ? w_head_a3 : 5'd0;

  // A retire frees a slot in the same cycle, so a full FIFO may still accept
  assign lu_ready  = !reset && (!w_full || w_retire);
  assign w_push    = lu_valid && lu_ready;

  // A saturated counter can still take an issue when that register retires now
  assign lu_issue_ok = !reset &&
                       !((r_cnt[lu_issue_a3] == c_MAXC) &&
                         !((w_ret_a3 == lu_issue_a3) && (lu_issue_a3 != 5'd0)));
  assign w_issue_eff = lu_issue && lu_issue_ok && (lu_issue_a3 != 5'd0);

  // One-hot increment/decrement requests per register for this cycle
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    if (w_issue_eff)
      w_inc[lu_issue_a3] = 1'b1;
    if (w_ret_a3 != 5'd0)
      w_dec[w_ret_a3] = 1'b1;
  end

  // Last outstanding write retiring now is forwarded by the GRF, so not busy
  assign w_b1_cnt = r_cnt[rd_a1] - (w_dec[rd_a1] ? c_CONE : '0);
  assign w_b2_cnt = r_cnt[rd_a2] - (w_dec[rd_a2] ? c_CONE : '0);
  assign busy1    = !reset && (rd_a1 != 5'd0) && (w_b1_cnt != '0);
  assign busy2    = !reset && (rd_a2 != 5'd0) && (w_b2_cnt != '0);

  assign pipe_stall = !reset && (r_wait >= c_MAXW);

  // Write-port mux: W stage first, then FIFO head, else idle
  always_comb begin
    grf_a3 = 5'd0;
    grf_wd = 32'd0;
    grf_pc = 32'd0;
    if (!reset) begin
      if (w_wstage) begin
        grf_a3 = w_a3;
        grf_wd = w_wd;
        grf_pc = w_pc;
      end else if (!w_empty) begin
        grf_a3 = w_head_a3;
        grf_wd = w_head_wd;
        grf_pc = w_head_pc;
      end
    end
  end

  // FIFO pointer advance and entry capture; reset discards queued results
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) begin
        r_fa3[r_wr[c_AW-1:0]] <= lu_a3;
        r_fwd[r_wr[c_AW-1:0]] <= lu_wd;
        r_fpc[r_wr[c_AW-1:0]] <= lu_pc;
        r_wr <= r_wr + c_PONE;
      end
      if (w_retire)
        r_rd <= r_rd + c_PONE;
    end
  end

  // Pending scoreboard; issue and retire on the same register cancel out
  always_ff @(posedge clk) begin
    for (int r = 0; r < 32; r++) begin
      if (reset || (r == 0))
        r_cnt[r] <= '0;
      else if (w_inc[r] && !w_dec[r])
        r_cnt[r] <= r_cnt[r] + c_CONE;
      else if (!w_inc[r] && w_dec[r])
        r_cnt[r] <= r_cnt[r] - c_CONE;
    end
  end

  // Starvation counter; saturates once the stall threshold is reached
  always_ff @(posedge clk) begin
    if (reset || w_empty || w_retire)
      r_wait <= '0;
    else if (r_wait < c_MAXW)
      r_wait <= r_wait + c_WONE;
  end

endmodule
`default_nettype wire

// File: tb/tb_grf_wb_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_grf_wb_arbiter                                            |
// | Purpose : Directed and randomized checks of grf_wb_arbiter against a   |
// |           queue-based behavioural model.                               |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_grf_wb_arbiter;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 2;
  localparam int MAXC     = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  w_a3;
  logic [31:0] w_wd, w_pc;
  logic        lu_issue;
  logic [4:0]  lu_issue_a3;
  logic        lu_issue_ok;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_a3;
  logic [31:0] lu_wd, lu_pc;
  logic [4:0]  rd_a1, rd_a2;
  logic        busy1, busy2, pipe_stall;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd, grf_pc;

  grf_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .w_a3(w_a3), .w_wd(w_wd), .w_pc(w_pc),
    .lu_issue(lu_issue), .lu_issue_a3(lu_issue_a3), .lu_issue_ok(lu_issue_ok),
    .lu_valid(lu_valid), .lu_ready(lu_ready),
    .lu_a3(lu_a3), .lu_wd(lu_wd), .lu_pc(lu_pc),
    .rd_a1(rd_a1), .rd_a2(rd_a2), .busy1(busy1), .busy2(busy2),
    .pipe_stall(pipe_stall),
    .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
  } ent_t;

  // Behavioural model state
  ent_t q[$];
  int   cnt[32];
  int   wt;
  logic e_retire, e_ready, e_ok;
  int   pend[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic go(input bit rs, input logic [4:0] wa3, input bit iss,
                    input logic [4:0] ia3, input bit v, input logic [4:0] la3,
                    input logic [31:0] lwd, input logic [31:0] lpc,
                    input logic [4:0] r1, input logic [4:0] r2);
    logic [4:0]  ret_a3;
    logic [4:0]  ea3;
    logic [31:0] ewd, epc;
    bit          b1, b2;
    reset = rs; w_a3 = wa3;
    w_wd = 32'hA5A5_0000 ^ {27'd0, wa3};
    w_pc = 32'h0000_1000 + {25'd0, wa3, 2'b00};
    lu_issue = iss; lu_issue_a3 = ia3;
    lu_valid = v; lu_a3 = la3; lu_wd = lwd; lu_pc = lpc;
    rd_a1 = r1; rd_a2 = r2;
    #1;
    if (rs) begin
      e_retire = 0; e_ready = 0; e_ok = 0;
      chk("rst_grf_a3", grf_a3, 0);
      chk("rst_ready", lu_ready, 0);
      chk("rst_issue_ok", lu_issue_ok, 0);
      chk("rst_stall", pipe_stall, 0);
      chk("rst_busy1", busy1, 0);
      chk("rst_busy2", busy2, 0);
    end else begin
      e_retire = (wa3 == 0) && (q.size() > 0);
      if (wa3 != 0) begin
        ea3 = wa3; ewd = w_wd; epc = w_pc;
      end else if (q.size() > 0) begin
        ea3 = q[0].a3; ewd = q[0].wd; epc = q[0].pc;
      end else begin
        ea3 = 0; ewd = 0; epc = 0;
      end
      ret_a3  = e_retire ? q[0].a3 : 5'd0;
      e_ready = (q.size() < DEPTH) || e_retire;
      e_ok    = !((cnt[ia3] == MAXC) && !((ret_a3 == ia3) && (ia3 != 0)));
      b1 = (r1 != 0) && ((cnt[r1] - ((ret_a3 == r1) ? 1 : 0)) != 0);
      b2 = (r2 != 0) && ((cnt[r2] - ((ret_a3 == r2) ? 1 : 0)) != 0);
      chk("grf_a3", grf_a3, ea3);
      chk("grf_wd", grf_wd, ewd);
      chk("grf_pc", grf_pc, epc);
      chk("lu_ready", lu_ready, e_ready);
      chk("issue_ok", lu_issue_ok, e_ok);
      chk("busy1", busy1, b1);
      chk("busy2", busy2, b2);
      chk("pipe_stall", pipe_stall, (wt >= MAX_WAIT));
    end
  endtask

  // Advance the model across the coming posedge, then wait for next negedge
  task automatic fin();
    bit   was_empty;
    ent_t e;
    if (reset) begin
      q.delete();
      foreach (cnt[i]) cnt[i] = 0;
      wt = 0;
    end else begin
      was_empty = (q.size() == 0);
      if (e_retire) begin
        if (q[0].a3 != 0) cnt[q[0].a3]--;
        q.delete(0);
      end
      if (lu_valid && e_ready) begin
        e.a3 = lu_a3; e.wd = lu_wd; e.pc = lu_pc;
        q.push_back(e);
      end
      if (lu_issue && e_ok && lu_issue_a3 != 0) cnt[lu_issue_a3]++;
      wt = (was_empty || e_retire) ? 0 : wt + 1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    go(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    repeat (n) begin
      go(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      fin();
    end
  endtask

  initial begin
    bit          rs, iss, v;
    logic [4:0]  wa3, ia3, la3;
    int          pidx;
    foreach (cnt[i]) cnt[i] = 0;
    wt = 0;
    do_reset(2);

    // Result retires the cycle after push; busy clears as it retires
    go(0, 0, 1, 8, 0, 0, 0, 0, 0, 0); fin();
    go(0, 0, 0, 0, 1, 8, 32'h1234, 32'h3000, 8, 0);
    chk("lit_busy_before", busy1, 1); fin();
    go(0, 0, 0, 0, 0, 0, 0, 0, 8, 0);
    chk("lit_ret_a3", grf_a3, 8);
    chk("lit_ret_wd", grf_wd, 32'h1234);
    chk("lit_ret_pc", grf_pc, 32'h3000);
    chk("lit_busy_ret", busy1, 0); fin();
    go(0, 0, 0, 0, 0, 0, 0, 0, 8, 0);
    chk("lit_busy_after", busy1, 0); fin();

    // Reset with two queued results discards them
    go(0, 3, 1, 5, 0, 0, 0, 0, 0, 0); fin();
    go(0, 3, 1, 5, 0, 0, 0, 0, 0, 0); fin();
    go(0, 3, 0, 0, 1, 5, 32'hAAAA, 32'h100, 0, 0); fin();
    go(0, 3, 0, 0, 1, 5, 32'hBBBB, 32'h104, 0, 0); fin();
    go(0, 3, 0, 0, 0, 0, 0, 0, 5, 0);
    chk("lit_full_busy", busy1, 1);
    chk("lit_full_ready", lu_ready, 0); fin();
    go(1, 0, 0, 0, 0, 0, 0, 0, 5, 0);
    chk("lit_rst_a3", grf_a3, 0); fin();
    go(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
    chk("lit_post_rst_a3", grf_a3, 0);
    chk("lit_post_rst_busy", busy1, 0);
    chk("lit_post_rst_ready", lu_ready, 1); fin();

    // Starvation: entry blocked by W for MAX_WAIT cycles raises pipe_stall
    go(0, 3, 1, 12, 0, 0, 0, 0, 0, 0); fin();
    go(0, 3, 0, 0, 1, 12, 32'hC0DE, 32'h200, 0, 0); fin();
    for (int i = 0; i < MAX_WAIT; i++) begin
      go(0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("lit_stall_low", pipe_stall, 0); fin();
    end
    go(0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_stall_high", pipe_stall, 1); fin();
    go(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_stall_ret_a3", grf_a3, 12);
    chk("lit_stall_ret_wd", grf_wd, 32'hC0DE); fin();
    idle();
    chk("lit_stall_clear", pipe_stall, 0); fin();

    // Full FIFO: retire and push in the same cycle, order preserved
    do_reset(1);
    go(0, 3, 1, 20, 0, 0, 0, 0, 0, 0); fin();
    go(0, 3, 1, 21, 0, 0, 0, 0, 0, 0); fin();
    go(0, 3, 0, 0, 1, 20, 32'h2020, 32'h420, 0, 0); fin();
    go(0, 3, 0, 0, 1, 21, 32'h2121, 32'h424, 0, 0); fin();
    go(0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_full_noready", lu_ready, 0); fin();
    go(0, 0, 0, 0, 1, 0, 32'h77, 32'h500, 0, 0);
    chk("lit_full_ready_ret", lu_ready, 1);
    chk("lit_order0", grf_a3, 20); fin();
    idle(); chk("lit_order1", grf_a3, 21); fin();
    idle();
    chk("lit_order2_a3", grf_a3, 0);
    chk("lit_order2_wd", grf_wd, 32'h77); fin();
    idle(); chk("lit_drained_wd", grf_wd, 0); fin();

    // Saturated counter: issue allowed only when that register retires
    do_reset(1);
    repeat (3) begin go(0, 0, 1, 9, 0, 0, 0, 0, 0, 0); fin(); end
    go(0, 3, 0, 9, 1, 9, 32'h99, 32'h600, 0, 0);
    chk("lit_sat_ok0", lu_issue_ok, 0); fin();
    go(0, 3, 0, 9, 0, 0, 0, 0, 0, 0);
    chk("lit_sat_ok1", lu_issue_ok, 0); fin();
    go(0, 0, 1, 9, 0, 0, 0, 0, 9, 0);
    chk("lit_sat_ret_ok", lu_issue_ok, 1);
    chk("lit_sat_ret_a3", grf_a3, 9);
    chk("lit_sat_busy", busy1, 1); fin();
    go(0, 3, 1, 9, 0, 0, 0, 0, 9, 0);
    chk("lit_sat_again", lu_issue_ok, 0); fin();
    go(0, 3, 0, 9, 0, 0, 0, 0, 9, 0);
    chk("lit_sat_held", lu_issue_ok, 0);
    chk("lit_sat_busy2", busy1, 1); fin();

    // Zero-destination result retires without touching anything
    do_reset(1);
    go(0, 0, 0, 0, 1, 0, 32'hFFFF, 32'h40, 0, 0);
    chk("lit_z_busy0", busy1, 0); fin();
    idle();
    chk("lit_z_a3", grf_a3, 0);
    chk("lit_z_wd", grf_wd, 32'hFFFF);
    chk("lit_z_busy1", busy1, 0); fin();
    idle(); chk("lit_z_empty", grf_wd, 0); fin();

    // Randomized traffic obeying the LU issue/result protocol
    do_reset(2);
    pend.delete();
    for (int n = 0; n < 3000; n++) begin
      rs  = ($urandom_range(0, 199) == 0);
      wa3 = ((wt >= MAX_WAIT) || ($urandom_range(0, 1) == 0)) ? 5'd0
                                                               : 5'($urandom_range(1, 31));
      iss = ($urandom_range(0, 2) == 0);
      ia3 = 5'($urandom_range(0, 7));
      v = 0; la3 = 0; pidx = -1;
      if ($urandom_range(0, 1) == 1) begin
        if (pend.size() > 0 && $urandom_range(0, 5) != 0) begin
          pidx = $urandom_range(0, pend.size() - 1);
          la3  = 5'(pend[pidx]);
          v    = 1;
        end else if ($urandom_range(0, 3) == 0) begin
          v = 1;
        end
      end
      go(rs, wa3, iss, ia3, v, la3, $urandom, $urandom,
         5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      if (rs) begin
        pend.delete();
      end else begin
        if (v && e_ready && pidx >= 0) pend.delete(pidx);
        if (iss && e_ok && ia3 != 0) pend.push_back(int'(ia3));
      end
      fin();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
